// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Saturation limits are only consumed when PIPELINED_ADDER_SAT_EN is defined.
package pipelined_adder_pkg;

    localparam int MAX_W = 1024;

    // Control half of a stage record; the data half is sized per stage in the top.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic logic [MAX_W-1:0] sat_pos(input int width);
        return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_neg(input int width);
        return MAX_W'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// CHUNK-bit combinational ripple adder built from full adders; also exposes
// the carry into its top bit so the last chunk can flag signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit ripple per stage, valid/ready on both sides.
// Define PIPELINED_ADDER_SAT_EN to clamp overflowing results to the signed limits.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // Handshake: a stage loads only when adv is high; the output slot frees when it is
    // consumed or empty, so in_ready = adv and a bubble at the output never stalls the pipe.
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             ovf_q;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int HI = WIDTH - k * CHUNK;
        localparam int LO = (k + 1) * CHUNK;

        logic [HI-1:0]    a_in;
        logic [HI-1:0]    b_in;
        stage_ctl_t       ctl_in;
        stage_ctl_t       ctl_q;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             cm;
        logic [LO-1:0]    sum_raw;
        logic [LO-1:0]    sum_d;
        logic [LO-1:0]    sum_q;

        adder_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a        (a_in[CHUNK-1:0]),
            .b        (b_in[CHUNK-1:0]),
            .cin      (ctl_in.carry),
            .sum      (s),
            .cout     (co),
            .c_msb_in (cm)
        );

        if (k == 0) begin : g_head
            assign a_in         = a;
            assign b_in         = b_eff;
            assign ctl_in.valid = in_valid;
            assign ctl_in.carry = cin_eff;
            assign sum_raw      = s;
        end else begin : g_tail
            // Skew registers: carry forward only the operand chunks not yet added.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_in <= '0;
                    b_in <= '0;
                end else if (adv) begin
                    a_in <= g_stage[k-1].a_in[WIDTH-(k-1)*CHUNK-1:CHUNK];
                    b_in <= g_stage[k-1].b_in[WIDTH-(k-1)*CHUNK-1:CHUNK];
                end
            end
            assign ctl_in  = g_stage[k-1].ctl_q;
            assign sum_raw = {s, g_stage[k-1].sum_q};
        end

        if (k == STAGES - 1) begin : g_last
`ifdef PIPELINED_ADDER_SAT_EN
            localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
            localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
            logic pos;
            assign pos   = ~a_in[CHUNK-1] & ~b_in[CHUNK-1];
            assign sum_d = (cm ^ co) ? (pos ? SAT_POS : SAT_NEG) : sum_raw;
`else
            assign sum_d = sum_raw;
`endif
        end else begin : g_mid
            logic unused_cm;
            assign unused_cm = cm;
            assign sum_d     = sum_raw;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
                sum_q <= '0;
            end else if (adv) begin
                ctl_q.valid <= ctl_in.valid;
                ctl_q.carry <= co;
                sum_q       <= sum_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_stage[STAGES-1].cm ^ g_stage[STAGES-1].co;
        end
    end

    assign out_valid = g_stage[STAGES-1].ctl_q.valid;
    assign cout      = g_stage[STAGES-1].ctl_q.carry;
    assign sum       = g_stage[STAGES-1].sum_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: an 8-bit/2-stage instance and a 16-bit/1-stage instance.
// Expectations follow PIPELINED_ADDER_SAT_EN when it is defined.
module tb_pipelined_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv8, ir8, ov8, or8, cin8, sub8, co8, of8;
    logic [7:0] a8, b8, s8;
    logic        iv16, ir16, ov16, or16, cin16, sub16, co16, of16;
    logic [15:0] a16, b16, s16;

    int n_cmp  = 0;
    int n_fail = 0;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(of8)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(of16)
    );

    // Independent reference: wide add, signed overflow from operand/result signs.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
        logic [15:0] yb;
        logic [16:0] f;
        logic [15:0] r;
        logic        o;
        yb = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, yb} + {16'b0, (s ? 1'b1 : c)};
        r  = f[15:0];
        o  = (x[15] == yb[15]) && (r[15] != x[15]);
`ifdef PIPELINED_ADDER_SAT_EN
        if (o) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {o, f[16], r};
    endfunction

    task automatic send_one(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                            input logic ts, output logic [7:0] rs, output logic rc,
                            output logic ro, output int lat);
        lat = -1;
        rs  = '0;
        rc  = 1'b0;
        ro  = 1'b0;
        @(negedge clk);
        a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            if (ov8) begin
                lat = i; rs = s8; rc = co8; ro = of8;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iv8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0; or8 = 1;
        iv16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0; or16 = 1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", ov8); end
        n_cmp++; if (s8 !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", s8); end
        n_cmp++; if (co8 !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", co8); end
        n_cmp++; if (of8 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", of8); end
        n_cmp++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid16: got %b want 0", ov16); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", ir8); end
    endtask

    task automatic test_add_carry();
        logic [7:0] rs; logic rc, ro; int lat;
        send_one(8'hFF, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", lat); end
        n_cmp++; if (rs !== 8'h00) begin n_fail++; $display("FAIL add_sum: got %h want 00", rs); end
        n_cmp++; if (rc !== 1'b1) begin n_fail++; $display("FAIL add_cout: got %b want 1", rc); end
        n_cmp++; if (ro !== 1'b0) begin n_fail++; $display("FAIL add_ovf: got %b want 0", ro); end
        send_one(8'h10, 8'h20, 1'b1, 1'b0, rs, rc, ro, lat);
        n_cmp++; if (rs !== 8'h31) begin n_fail++; $display("FAIL add_cin_sum: got %h want 31", rs); end
    endtask

    task automatic test_overflow();
        logic [7:0] rs, want; logic rc, ro; int lat;
`ifdef PIPELINED_ADDER_SAT_EN
        want = 8'h7F;
`else
        want = 8'h80;
`endif
        send_one(8'h7F, 8'h01, 1'b0, 1'b0, rs, rc, ro, lat);
        n_cmp++; if (rs !== want) begin n_fail++; $display("FAIL ovf_pos_sum: got %h want %h", rs, want); end
        n_cmp++; if (ro !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_flag: got %b want 1", ro); end
        n_cmp++; if (rc !== 1'b0) begin n_fail++; $display("FAIL ovf_pos_cout: got %b want 0", rc); end
        send_one(8'h80, 8'h01, 1'b0, 1'b1, rs, rc, ro, lat);
        n_cmp++; if (rs !== 8'h7F ^ ((want == 8'h7F) ? 8'hFF : 8'h00)) begin
            n_fail++; $display("FAIL ovf_neg_sum: got %h", rs);
        end
        n_cmp++; if ({ro, rc} !== 2'b11) begin n_fail++; $display("FAIL ovf_neg_flags: got %b%b want 11", ro, rc); end
    endtask

    task automatic test_sub();
        logic [7:0] rs; logic rc, ro; int lat;
        for (int c = 1; c >= 0; c--) begin
            send_one(8'h05, 8'h07, c[0], 1'b1, rs, rc, ro, lat);
            n_cmp++; if ({ro, rc, rs} !== {1'b0, 1'b0, 8'hFE}) begin
                n_fail++; $display("FAIL sub_borrow cin=%0d: got ovf=%b cout=%b sum=%h want 0 0 fe", c, ro, rc, rs);
            end
        end
        send_one(8'h07, 8'h05, 1'b0, 1'b1, rs, rc, ro, lat);
        n_cmp++; if ({ro, rc, rs} !== {1'b0, 1'b1, 8'h02}) begin
            n_fail++; $display("FAIL sub_no_borrow: got ovf=%b cout=%b sum=%h want 0 1 02", ro, rc, rs);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic       vs [4];
        logic [9:0] ve [4];
        logic [9:0] exp_q[$];
        logic [9:0] held, got_v;
        logic       stalled_prev;
        int         idx, got;
        va = '{8'h12, 8'hF0, 8'h40, 8'h30};
        vb = '{8'h34, 8'h20, 8'h40, 8'h10};
        vs = '{1'b0, 1'b0, 1'b0, 1'b1};
        ve[0] = {1'b0, 1'b0, 8'h46};
        ve[1] = {1'b0, 1'b1, 8'h10};
`ifdef PIPELINED_ADDER_SAT_EN
        ve[2] = {1'b1, 1'b0, 8'h7F};
`else
        ve[2] = {1'b1, 1'b0, 8'h80};
`endif
        ve[3] = {1'b0, 1'b1, 8'h20};
        idx = 0; got = 0; stalled_prev = 1'b0; held = '0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(negedge clk);
            iv8 = (idx < 4);
            if (idx < 4) begin a8 = va[idx]; b8 = vb[idx]; sub8 = vs[idx]; cin8 = 1'b0; end
            or8 = !(cyc >= 3 && cyc <= 5);
            #1;
            got_v = {of8, co8, s8};
            if (stalled_prev) begin
                n_cmp++; if (ov8 !== 1'b1 || got_v !== held) begin
                    n_fail++; $display("FAIL b2b_hold cyc=%0d: got v=%b %h want v=1 %h", cyc, ov8, got_v, held);
                end
            end
            if (ov8 && !or8) begin
                n_cmp++; if (ir8 !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready cyc=%0d: got %b want 0", cyc, ir8); end
            end
            if (ov8 && or8) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra cyc=%0d: got %h want none", cyc, got_v);
                end else if (got_v !== exp_q[0]) begin
                    n_fail++; $display("FAIL b2b_data cyc=%0d: got %h want %h", cyc, got_v, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (iv8 && ir8) begin exp_q.push_back(ve[idx]); idx++; end
            stalled_prev = ov8 && !or8;
            held = got_v;
        end
        @(negedge clk);
        iv8 = 1'b0; or8 = 1'b1;
        n_cmp++; if (got !== 4 || idx !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d out %0d in want 4 4", got, idx); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        or8 = 1'b1; iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; sub8 = 1'b0;
        @(negedge clk);
        a8 = 8'h03; b8 = 8'h04;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        n_cmp++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before: got %b want 1", ov8); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop: got %b want 0", ov8); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ov8) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_no_result: got %b want 0", seen); end
    endtask

    task automatic test_single_stage();
        logic [15:0] da [4];
        logic [15:0] db [4];
        logic        ds [4];
        logic [17:0] exp_q[$];
        int          acc_q[$];
        logic [17:0] got_v;
        logic        prev_ov, prev_pop, took;
        int          sent, got;
        da = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005};
        db = '{16'h0001, 16'h0001, 16'h0001, 16'h0007};
        ds = '{1'b0, 1'b0, 1'b1, 1'b1};
        sent = 0; got = 0; prev_ov = 1'b0; prev_pop = 1'b0; took = 1'b0;
        for (int cyc = 0; cyc < 4000 && got < 300; cyc++) begin
            @(negedge clk);
            if (!iv16 || took) begin
                if (sent < 4) begin
                    iv16 = 1'b1; a16 = da[sent]; b16 = db[sent]; sub16 = ds[sent]; cin16 = 1'b0;
                end else if (sent < 300 && $urandom_range(0, 3) != 0) begin
                    iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
                    cin16 = 1'($urandom); sub16 = 1'($urandom);
                end else begin
                    iv16 = 1'b0;
                end
            end
            or16 = ($urandom_range(0, 2) != 0);
            #1;
            got_v = {of16, co16, s16};
            if (ov16 && (!prev_ov || prev_pop)) begin
                n_cmp++; if (acc_q.size() == 0 || cyc !== acc_q[0] + 1) begin
                    n_fail++; $display("FAIL s1_latency cyc=%0d: got %0d want 1", cyc,
                                       (acc_q.size() == 0) ? -1 : cyc - acc_q[0]);
                end
            end
            if (ov16 && or16) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL s1_extra cyc=%0d: got %h want none", cyc, got_v);
                end else begin
                    if (got_v !== exp_q[0]) begin
                        n_fail++; $display("FAIL s1_data cyc=%0d: got %h want %h", cyc, got_v, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                end
                got++;
            end
            took = iv16 && ir16;
            if (took) begin
                exp_q.push_back(model16(a16, b16, cin16, sub16));
                acc_q.push_back(cyc);
                sent++;
            end
            prev_ov  = ov16;
            prev_pop = ov16 && or16;
        end
        @(negedge clk);
        iv16 = 1'b0;
        n_cmp++; if (got !== 300 || exp_q.size() !== 0) begin
            n_fail++; $display("FAIL s1_count: got %0d results, %0d pending want 300 0", got, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_overflow();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_single_stage();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
